// File: rtl/packet_transmitter.sv
// Device-to-host packet serialiser: accepts one read, write or done request at a
// time and streams header byte plus MSB-first payload toward the UART transmitter.
module packet_transmitter (
    input  logic         clk,
    input  logic         reset,
    input  logic         mem_read_stb,
    input  logic [15:0]  mem_read_addr,
    output logic         mem_read_ready,
    input  logic         mem_write_stb,
    input  logic [15:0]  mem_write_addr,
    input  logic [287:0] mem_write_matrix_tile,
    output logic         mem_write_ready,
    input  logic         program_done_stb,
    input  logic [7:0]   program_done_id,
    output logic         program_done_ready,
    input  logic         tx_ready,
    output logic         tx_stb,
    output logic [7:0]   tx_data,
    output logic         busy
);

    // Handshake: every port pair transfers exactly on a cycle where stb && ready;
    // a source holds stb and its data stable until that cycle, and tx_stb/tx_data
    // obey the same rule toward the UART.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    localparam logic [7:0] HDR_READ  = 8'h09;  // len 2,  type 1
    localparam logic [7:0] HDR_WRITE = 8'h9A;  // len 38, type 2
    localparam logic [7:0] HDR_DONE  = 8'h07;  // len 1,  type 3

    state_t       state;
    logic [303:0] shift_reg;
    logic [5:0]   byte_cnt;
    logic         can_accept;

    assign can_accept         = (state == IDLE) && !reset;
    assign mem_write_ready    = can_accept && mem_write_stb;
    assign mem_read_ready     = can_accept && mem_read_stb && !mem_write_stb;
    assign program_done_ready = can_accept && program_done_stb && !mem_write_stb && !mem_read_stb;
    assign busy               = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            byte_cnt  <= '0;
            tx_stb    <= 1'b0;
            tx_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_write_ready) begin
                        shift_reg <= {mem_write_addr, mem_write_matrix_tile};
                        byte_cnt  <= 6'd38;
                        tx_data   <= HDR_WRITE;
                        tx_stb    <= 1'b1;
                        state     <= HEADER;
                    end else if (mem_read_ready) begin
                        shift_reg <= {mem_read_addr, 288'd0};
                        byte_cnt  <= 6'd2;
                        tx_data   <= HDR_READ;
                        tx_stb    <= 1'b1;
                        state     <= HEADER;
                    end else if (program_done_ready) begin
                        shift_reg <= {program_done_id, 296'd0};
                        byte_cnt  <= 6'd1;
                        tx_data   <= HDR_DONE;
                        tx_stb    <= 1'b1;
                        state     <= HEADER;
                    end
                end
                HEADER: begin
                    if (tx_ready) begin
                        tx_data <= shift_reg[303:296];
                        state   <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (tx_ready) begin
                        // tx_data always mirrors the top byte of the shifted register
                        shift_reg <= shift_reg << 8;
                        byte_cnt  <= byte_cnt - 6'd1;
                        if (byte_cnt == 6'd1) begin
                            tx_stb  <= 1'b0;
                            tx_data <= '0;
                            state   <= IDLE;
                        end else begin
                            tx_data <= shift_reg[295:288];
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_stb <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_packet_transmitter.sv
// Directed bench for packet_transmitter: byte streams, stalls, priority,
// busy-time requests and mid-packet reset against hand-computed packets.
module tb_packet_transmitter;

    logic         clk = 1'b0;
    logic         reset;
    logic         mem_read_stb;
    logic [15:0]  mem_read_addr;
    logic         mem_read_ready;
    logic         mem_write_stb;
    logic [15:0]  mem_write_addr;
    logic [287:0] mem_write_matrix_tile;
    logic         mem_write_ready;
    logic         program_done_stb;
    logic [7:0]   program_done_id;
    logic         program_done_ready;
    logic         tx_ready;
    logic         tx_stb;
    logic [7:0]   tx_data;
    logic         busy;

    packet_transmitter dut (
        .clk(clk), .reset(reset),
        .mem_read_stb(mem_read_stb), .mem_read_addr(mem_read_addr), .mem_read_ready(mem_read_ready),
        .mem_write_stb(mem_write_stb), .mem_write_addr(mem_write_addr),
        .mem_write_matrix_tile(mem_write_matrix_tile), .mem_write_ready(mem_write_ready),
        .program_done_stb(program_done_stb), .program_done_id(program_done_id),
        .program_done_ready(program_done_ready),
        .tx_ready(tx_ready), .tx_stb(tx_stb), .tx_data(tx_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Monitor: records UART transfers, busy cycles and request acceptances
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int cyc = 0, busy_cycles = 0;
    int n_acc_w = 0, n_acc_r = 0, n_acc_d = 0;
    int acc_cyc_w = 0, acc_cyc_r = 0, acc_cyc_d = 0;

    always @(posedge clk) begin
        if (tx_stb && tx_ready) rx_q.push_back(tx_data);
        if (busy) busy_cycles++;
        if (mem_write_stb && mem_write_ready) begin n_acc_w++; acc_cyc_w = cyc; end
        if (mem_read_stb && mem_read_ready) begin n_acc_r++; acc_cyc_r = cyc; end
        if (program_done_stb && program_done_ready) begin n_acc_d++; acc_cyc_d = cyc; end
        cyc++;
    end

    int n_checks = 0, n_pass = 0;

    task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((busy || tx_stb) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 288'(n < budget), 288'd1);
    endtask

    task automatic compare_rx(input string tag, input int base);
        int got;
        got = rx_q.size() - base;
        check({tag, "_len"}, 288'(got), 288'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got; i++)
            check($sformatf("%s_byte%0d", tag, i), 288'(rx_q[base + i]), 288'(exp_q[i]));
    endtask

    logic [287:0] tile, tile_rx;
    int base, b0, w0, r0, d0, n;
    logic done_all;

    initial begin
        reset = 1'b1;
        mem_read_stb = 1'b0; mem_read_addr = '0;
        mem_write_stb = 1'b0; mem_write_addr = '0; mem_write_matrix_tile = '0;
        program_done_stb = 1'b0; program_done_id = '0;
        tx_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_tx_stb", 288'(tx_stb), 288'd0);
        check("rst_tx_data", 288'(tx_data), 288'd0);
        check("rst_busy", 288'(busy), 288'd0);
        check("rst_ready", 288'({mem_read_ready, mem_write_ready, program_done_ready}), 288'd0);
        reset = 1'b0;
        @(negedge clk);

        // Read 0x1234 with tx_ready high: 09 12 34 on consecutive cycles
        tx_ready = 1'b1;
        base = rx_q.size(); b0 = busy_cycles;
        mem_read_stb = 1'b1; mem_read_addr = 16'h1234;
        #1;
        check("rd_ready", 288'({mem_write_ready, mem_read_ready, program_done_ready}), 288'b010);
        @(negedge clk);
        mem_read_stb = 1'b0;
        #1;
        check("rd_ready_pulse", 288'(mem_read_ready), 288'd0);
        check("rd_hdr", 288'({tx_stb, tx_data}), 288'({1'b1, 8'h09}));
        @(negedge clk);
        check("rd_b1", 288'({tx_stb, tx_data}), 288'({1'b1, 8'h12}));
        @(negedge clk);
        check("rd_b2", 288'({tx_stb, tx_data}), 288'({1'b1, 8'h34}));
        @(negedge clk);
        check("rd_end", 288'({tx_stb, busy}), 288'd0);
        check("rd_busy_cycles", 288'(busy_cycles - b0), 288'd3);
        exp_q = '{8'h09, 8'h12, 8'h34};
        compare_rx("rd", base);

        // Write 0xBEEF, tile bytes 0x00..0x23 MSB first; host model reassembles tile
        for (int k = 0; k < 36; k++) tile[287 - 8*k -: 8] = 8'(k);
        base = rx_q.size(); b0 = busy_cycles;
        mem_write_stb = 1'b1; mem_write_addr = 16'hBEEF; mem_write_matrix_tile = tile;
        #1;
        check("wr_ready", 288'({mem_write_ready, mem_read_ready, program_done_ready}), 288'b100);
        @(negedge clk);
        mem_write_stb = 1'b0;
        wait_idle("wr", 100);
        check("wr_busy_cycles", 288'(busy_cycles - b0), 288'd39);
        exp_q = '{8'h9A, 8'hBE, 8'hEF};
        for (int k = 0; k < 36; k++) exp_q.push_back(8'(k));
        compare_rx("wr", base);
        tile_rx = '0;
        for (int k = 0; k < 36 && base + 3 + k < rx_q.size(); k++)
            tile_rx[287 - 8*k -: 8] = rx_q[base + 3 + k];
        check("wr_tile", tile_rx, tile);

        // Done 0x5A with stalls: data held through tx_ready=0 cycles
        @(negedge clk);
        base = rx_q.size();
        tx_ready = 1'b0;
        program_done_stb = 1'b1; program_done_id = 8'h5A;
        #1;
        check("dn_ready", 288'(program_done_ready), 288'd1);
        @(negedge clk); program_done_stb = 1'b0; tx_ready = 1'b0; #1;
        check("dn_hdr_stall", 288'({tx_stb, tx_data}), 288'({1'b1, 8'h07}));
        @(negedge clk); tx_ready = 1'b1; #1;
        check("dn_hdr_xfer", 288'({tx_stb, tx_data}), 288'({1'b1, 8'h07}));
        @(negedge clk); tx_ready = 1'b0; #1;
        check("dn_id_stall1", 288'({tx_stb, tx_data}), 288'({1'b1, 8'h5A}));
        @(negedge clk); tx_ready = 1'b0; #1;
        check("dn_id_stall2", 288'({tx_stb, tx_data}), 288'({1'b1, 8'h5A}));
        @(negedge clk); tx_ready = 1'b1; #1;
        check("dn_id_xfer", 288'({tx_stb, tx_data}), 288'({1'b1, 8'h5A}));
        @(negedge clk);
        check("dn_end", 288'({tx_stb, busy}), 288'd0);
        exp_q = '{8'h07, 8'h5A};
        compare_rx("dn", base);

        // Simultaneous requests: write, then read, then done with one IDLE gap each
        base = rx_q.size();
        w0 = n_acc_w; r0 = n_acc_r; d0 = n_acc_d;
        mem_write_stb = 1'b1; mem_write_addr = 16'h0102; mem_write_matrix_tile = ~tile;
        mem_read_stb = 1'b1; mem_read_addr = 16'hC0DE;
        program_done_stb = 1'b1; program_done_id = 8'hA5;
        done_all = 1'b0; n = 0;
        while (!done_all && n < 200) begin
            if (n_acc_w > w0) mem_write_stb = 1'b0;
            if (n_acc_r > r0) mem_read_stb = 1'b0;
            if (n_acc_d > d0) program_done_stb = 1'b0;
            #1;
            check("pri_onehot", 288'($countones({mem_write_ready, mem_read_ready, program_done_ready}) <= 1), 288'd1);
            if (busy) check("pri_ready_busy", 288'({mem_write_ready, mem_read_ready, program_done_ready}), 288'd0);
            done_all = !mem_write_stb && !mem_read_stb && !program_done_stb && !busy;
            @(negedge clk);
            n++;
        end
        check("pri_timeout", 288'(n < 200), 288'd1);
        check("pri_gap_rd", 288'(acc_cyc_r - acc_cyc_w), 288'd40);
        check("pri_gap_dn", 288'(acc_cyc_d - acc_cyc_r), 288'd4);
        exp_q = '{8'h9A, 8'h01, 8'h02};
        for (int k = 0; k < 36; k++) exp_q.push_back(~8'(k));
        exp_q.push_back(8'h09); exp_q.push_back(8'hC0); exp_q.push_back(8'hDE);
        exp_q.push_back(8'h07); exp_q.push_back(8'hA5);
        compare_rx("pri", base);

        // Read arriving while busy: held off until IDLE; later address change ignored
        @(negedge clk);
        base = rx_q.size();
        tx_ready = 1'b0;
        program_done_stb = 1'b1; program_done_id = 8'h33;
        @(negedge clk);
        program_done_stb = 1'b0;
        mem_read_stb = 1'b1; mem_read_addr = 16'hAAAA;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("busy_rd_held", 288'(mem_read_ready), 288'd0);
            @(negedge clk);
        end
        tx_ready = 1'b1;
        r0 = n_acc_r; n = 0;
        while (n_acc_r == r0 && n < 20) begin
            @(negedge clk);
            #1;
            if (busy) check("busy_rd_ready", 288'(mem_read_ready), 288'd0);
            n++;
        end
        check("busy_rd_timeout", 288'(n < 20), 288'd1);
        mem_read_stb = 1'b0; mem_read_addr = 16'h5555;
        wait_idle("busy_rd", 20);
        exp_q = '{8'h07, 8'h33, 8'h09, 8'hAA, 8'hAA};
        compare_rx("busy", base);

        // Reset after the 10th write byte, then a clean read
        @(negedge clk);
        base = rx_q.size();
        mem_write_stb = 1'b1; mem_write_addr = 16'h1111; mem_write_matrix_tile = tile;
        @(negedge clk);
        mem_write_stb = 1'b0;
        n = 0;
        while (rx_q.size() - base < 10 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_timeout", 288'(n < 50), 288'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_tx_stb", 288'(tx_stb), 288'd0);
        check("rst_mid_busy", 288'(busy), 288'd0);
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_count", 288'(rx_q.size() - base), 288'd10);
        @(negedge clk);
        base = rx_q.size();
        mem_read_stb = 1'b1; mem_read_addr = 16'h0F0F;
        @(negedge clk);
        mem_read_stb = 1'b0;
        wait_idle("post_rst", 20);
        exp_q = '{8'h09, 8'h0F, 8'h0F};
        compare_rx("post_rst", base);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
